// File: rtl/retention_ctrl_pkg.sv
// Shared types for the retention power controller: state encoding and per-state output decode.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
//
// Contents:
//   ret_state_t    4-bit FSM state, RUN=0 .. DEISO=9
//   *_STATES       one bit per state (bit index = state code), 1 where the output is asserted
//   ret_out_t      bundle of the decoded control outputs
//   ret_decode()   state -> ret_out_t, usable by benches to interpret the debug state port
package retention_ctrl_pkg;

  typedef enum logic [3:0] {
    RUN       = 4'd0,
    SAVE      = 4'd1,
    ISO       = 4'd2,
    PD_WAIT   = 4'd3,
    PD_SETTLE = 4'd4,
    OFF       = 4'd5,
    PU_WAIT   = 4'd6,
    PU_SETTLE = 4'd7,
    RESTORE   = 4'd8,
    DEISO     = 4'd9
  } ret_state_t;

  // Bit i set means the output is high while the FSM is in state i.
  localparam logic [9:0] CLK_EN_STATES    = 10'h303;  // RUN, SAVE, RESTORE, DEISO
  localparam logic [9:0] ISO_EN_STATES    = 10'h1FC;  // ISO .. RESTORE
  localparam logic [9:0] PWR_EN_STATES    = 10'h3C7;  // all but PD_WAIT, PD_SETTLE, OFF
  localparam logic [9:0] SAVE_STATES      = 10'h002;  // SAVE
  localparam logic [9:0] RESTORE_STATES   = 10'h100;  // RESTORE
  localparam logic [9:0] SLEEP_ACK_STATES = 10'h020;  // OFF

  typedef struct packed {
    logic clk_en;
    logic save;
    logic restore;
    logic iso_en;
    logic pwr_en;
    logic sleep_ack;
  } ret_out_t;

  function automatic ret_out_t ret_decode(input ret_state_t s);
    ret_out_t o;
    o.clk_en    = CLK_EN_STATES[s];
    o.save      = SAVE_STATES[s];
    o.restore   = RESTORE_STATES[s];
    o.iso_en    = ISO_EN_STATES[s];
    o.pwr_en    = PWR_EN_STATES[s];
    o.sleep_ack = SLEEP_ACK_STATES[s];
    return o;
  endfunction

endpackage

// File: rtl/retention_power_controller.sv
// Power-gating sequencer for one retention domain: save, isolate, gate clock, switch off; reverse on wake.
// Latency: outputs are registered Moore decodes of the state; inputs act on the following edge.
// Backpressure: pwr_ack gates PD_WAIT/PU_WAIT; sleep_req only sampled in RUN and OFF, never aborts a sequence.
//
// Ports:
//   clk, rst          always-on clock, synchronous active-high reset
//   sleep_req         1 = request retention, 0 = request run (level)
//   pwr_ack           power switch status, 1 = domain powered
//   clk_en            domain clock enable
//   save, restore     one-cycle strobes to the retention registers
//   iso_en            isolation clamp enable
//   pwr_en            power switch enable, 1 = on
//   sleep_ack         high only in OFF
//   err               sticky switch-timeout flag
//   state             current FSM state (debug)
module retention_power_controller
  import retention_ctrl_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ACK_TIMEOUT   = 64,
  parameter int CNT_W         = $clog2(ACK_TIMEOUT + SETTLE_CYCLES) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       pwr_ack,
  output logic       clk_en,
  output logic       save,
  output logic       restore,
  output logic       iso_en,
  output logic       pwr_en,
  output logic       sleep_ack,
  output logic       err,
  output logic [3:0] state
);

  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  ret_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             cnt_hold;
  ret_out_t         out_q;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    cnt_hold = 1'b0;
    case (state_q)
      RUN:       if (sleep_req) state_d = SAVE;
      SAVE:      state_d = ISO;
      ISO:       state_d = PD_WAIT;
      PD_WAIT: begin
        if (!pwr_ack) begin
          state_d = PD_SETTLE;
        end else if (cnt_q == ACK_LAST) begin
          // Switch never turned off: abandon the entry and bring the domain back up.
          state_d = PU_WAIT;
          err_d   = 1'b1;
        end
      end
      PD_SETTLE: if (cnt_q == SETTLE_LAST) state_d = OFF;
      OFF:       if (!sleep_req) state_d = PU_WAIT;
      PU_WAIT: begin
        if (pwr_ack) begin
          state_d = PU_SETTLE;
        end else if (cnt_q == ACK_LAST) begin
          // Nowhere safe to go without power: keep waiting, flag it, freeze the counter.
          err_d    = 1'b1;
          cnt_hold = 1'b1;
        end
      end
      PU_SETTLE: if (cnt_q == SETTLE_LAST) state_d = RESTORE;
      RESTORE:   state_d = DEISO;
      DEISO:     state_d = RUN;
      default:   state_d = RUN;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_hold) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they always equal decode(state_q).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= ret_decode(RUN);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= ret_decode(state_d);
    end
  end

  assign clk_en    = out_q.clk_en;
  assign save      = out_q.save;
  assign restore   = out_q.restore;
  assign iso_en    = out_q.iso_en;
  assign pwr_en    = out_q.pwr_en;
  assign sleep_ack = out_q.sleep_ack;
  assign err       = err_q;
  assign state     = state_q;

endmodule

// File: tb/tb_retention_power_controller.sv
// Bench for retention_power_controller with a behavioural retention register; pwr_ack is driven per cycle.
// Latency: one expected record per clock, compared just after the edge it describes.
// Backpressure: none; stimulus and monitor are decoupled through the expectation queues.
module tb_retention_power_controller;
  import retention_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       sleep_req;
  logic       pwr_ack;
  logic       clk_en, save, restore, iso_en, pwr_en, sleep_ack, err;
  logic [3:0] state;

  retention_power_controller #(
    .SETTLE_CYCLES(4),
    .ACK_TIMEOUT  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sleep_req(sleep_req),
    .pwr_ack  (pwr_ack),
    .clk_en   (clk_en),
    .save     (save),
    .restore  (restore),
    .iso_en   (iso_en),
    .pwr_en   (pwr_en),
    .sleep_ack(sleep_ack),
    .err      (err),
    .state    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Retention register in the switched domain: loses its value while unpowered.
  logic [31:0] dom_q, shadow_q, dom_wdat;
  logic        dom_wr;
  always @(posedge clk) begin
    if (save) shadow_q <= dom_q;
    if (!pwr_ack)                dom_q <= 32'h0;
    else if (restore)            dom_q <= shadow_q;
    else if (clk_en && dom_wr)   dom_q <= dom_wdat;
  end

  // Scoreboard
  ret_state_t  exp_st_q[$];
  logic        exp_err_q[$];
  string       exp_nm_q[$];
  logic        exp_dchk_q[$];
  logic [31:0] exp_dat_q[$];
  logic        dchk_next;
  logic [31:0] dat_next;
  logic        err_exp;
  int          checks;
  int          errors;

  // Hand table of {clk_en, save, restore, iso_en, pwr_en, sleep_ack} per state.
  function automatic logic [5:0] exp_outs(input ret_state_t s);
    case (s)
      RUN:       return 6'b100010;
      SAVE:      return 6'b110010;
      ISO:       return 6'b000110;
      PD_WAIT:   return 6'b000100;
      PD_SETTLE: return 6'b000100;
      OFF:       return 6'b000101;
      PU_WAIT:   return 6'b000110;
      PU_SETTLE: return 6'b000110;
      RESTORE:   return 6'b101110;
      DEISO:     return 6'b100010;
      default:   return 6'b000000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    ret_state_t  es;
    logic        ee, dc;
    logic [31:0] ed;
    string       nm;
    logic [5:0]  o;
    forever begin
      @(posedge clk);
      #2;
      if (exp_st_q.size() > 0) begin
        es = exp_st_q.pop_front();
        ee = exp_err_q.pop_front();
        nm = exp_nm_q.pop_front();
        dc = exp_dchk_q.pop_front();
        ed = exp_dat_q.pop_front();
        o  = exp_outs(es);
        chk({nm, " state"},     32'(state),     32'(es));
        chk({nm, " clk_en"},    32'(clk_en),    32'(o[5]));
        chk({nm, " save"},      32'(save),      32'(o[4]));
        chk({nm, " restore"},   32'(restore),   32'(o[3]));
        chk({nm, " iso_en"},    32'(iso_en),    32'(o[2]));
        chk({nm, " pwr_en"},    32'(pwr_en),    32'(o[1]));
        chk({nm, " sleep_ack"}, 32'(sleep_ack), 32'(o[0]));
        chk({nm, " err"},       32'(err),       32'(ee));
        if (dc) chk({nm, " data"}, dom_q, ed);
      end
    end
  end

  // One clock of stimulus; es/ee describe the cycle that follows the next rising edge.
  task automatic cyc(input logic rs, input logic sr, input logic pa,
                     input ret_state_t es, input logic ee, input string nm);
    @(negedge clk);
    rst       = rs;
    sleep_req = sr;
    pwr_ack   = pa;
    exp_st_q.push_back(es);
    exp_err_q.push_back(ee);
    exp_nm_q.push_back(nm);
    exp_dchk_q.push_back(dchk_next);
    exp_dat_q.push_back(dat_next);
    dchk_next = 1'b0;
  endtask

  // Entry from RUN: switch acknowledges k cycles late; hold is sleep_req after the first cycle.
  task automatic enter(input int k, input logic hold, input string nm);
    cyc(0, 1,    1, SAVE,    err_exp, nm);
    cyc(0, hold, 1, ISO,     err_exp, nm);
    cyc(0, hold, 1, PD_WAIT, err_exp, nm);
    for (int i = 0; i < k; i++) cyc(0, hold, 1, PD_WAIT, err_exp, nm);
    for (int i = 0; i < 4; i++) cyc(0, hold, 0, PD_SETTLE, err_exp, nm);
    cyc(0, hold, 0, OFF, err_exp, nm);
  endtask

  // Exit from OFF: switch acknowledges j cycles late; sr is sleep_req after the wake sample.
  task automatic leave(input int j, input logic sr, input string nm);
    cyc(0, 0, 0, PU_WAIT, err_exp, nm);
    for (int i = 0; i < j; i++) cyc(0, sr, 0, PU_WAIT, err_exp | (i >= 15), nm);
    if (j >= 16) err_exp = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, sr, 1, PU_SETTLE, err_exp, nm);
    cyc(0, sr, 1, RESTORE, err_exp, nm);
    cyc(0, sr, 1, DEISO,   err_exp, nm);
    cyc(0, sr, 1, RUN,     err_exp, nm);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    sleep_req = 1'b0;
    pwr_ack   = 1'b1;
    dom_wr    = 1'b0;
    dom_wdat  = 32'h0;
    dchk_next = 1'b0;
    dat_next  = 32'h0;
    err_exp   = 1'b0;

    cyc(1, 0, 1, RUN, 0, "reset");
    dom_wr   = 1'b1;
    dom_wdat = 32'hDEADBEEF;
    cyc(0, 0, 1, RUN, 0, "write");
    dom_wr    = 1'b0;
    dchk_next = 1'b1; dat_next = 32'hDEADBEEF;
    cyc(0, 0, 1, RUN, 0, "written");

    // Basic cycle, k=0 and j=0: OFF (sleep_ack) in cycle 8, RESTORE 6 cycles after wake sample.
    enter(0, 1, "basic_in");
    dchk_next = 1'b1; dat_next = 32'h0;
    cyc(0, 1, 0, OFF, 0, "basic_off");
    dchk_next = 1'b1; dat_next = 32'h0;
    cyc(0, 1, 0, OFF, 0, "basic_off");
    leave(0, 0, "basic_out");
    dchk_next = 1'b1; dat_next = 32'hDEADBEEF;
    cyc(0, 0, 1, RUN, 0, "basic_run");

    // Slow switch: falls 5 late, rises 7 late.
    enter(5, 1, "slow_in");
    leave(7, 0, "slow_out");
    dchk_next = 1'b1; dat_next = 32'hDEADBEEF;
    cyc(0, 0, 1, RUN, 0, "slow_run");

    // One-cycle request pulse: full entry, OFF for exactly one cycle.
    enter(0, 0, "pulse_in");
    leave(0, 0, "pulse_out");

    // Request re-raised during PU_SETTLE: RUN for one cycle, then SAVE.
    enter(0, 1, "reraise_in");
    leave(0, 1, "reraise_out");
    enter(0, 1, "reraise_again");
    leave(0, 0, "reraise_wake");

    // Power-down timeout: switch stuck on, 16 cycles of PD_WAIT then abort to wake.
    cyc(0, 1, 1, SAVE,    0, "pdto");
    cyc(0, 0, 1, ISO,     0, "pdto");
    cyc(0, 0, 1, PD_WAIT, 0, "pdto");
    for (int i = 0; i < 15; i++) cyc(0, 0, 1, PD_WAIT, 0, "pdto_wait");
    cyc(0, 0, 1, PU_WAIT, 1, "pdto_abort");
    err_exp = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, PU_SETTLE, 1, "pdto_settle");
    cyc(0, 0, 1, RESTORE, 1, "pdto");
    cyc(0, 0, 1, DEISO,   1, "pdto");
    dchk_next = 1'b1; dat_next = 32'hDEADBEEF;
    cyc(0, 0, 1, RUN,     1, "pdto_run");
    cyc(0, 0, 1, RUN,     1, "pdto_sticky");

    cyc(1, 0, 1, RUN, 0, "reset2");
    err_exp = 1'b0;

    // Power-up timeout: switch stuck off for 21 PU_WAIT cycles, then releases.
    enter(0, 1, "puto_in");
    leave(20, 0, "puto_out");
    cyc(0, 0, 1, RUN, 1, "puto_sticky");

    // Reset in OFF: back to RUN with power on and no isolation.
    cyc(1, 0, 1, RUN, 0, "reset3");
    err_exp = 1'b0;
    enter(0, 1, "rstoff_in");
    cyc(0, 1, 0, OFF, 0, "rstoff_off");
    cyc(1, 1, 0, RUN, 0, "rstoff_rst");
    cyc(0, 0, 1, RUN, 0, "rstoff_run");

    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_st_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
